conv_bank_reader: RTL and testbench
===================================

# conv_bank_reader

Drains the convolution output ping-pong buffer after each convolution pass and streams it to the next layer. When the convolution controller reports mode == DONE, the block latches the bank just written (mem_sel: 0 = c bank, 1 = d bank). It then reads DEPTH words from that bank, from address 0 upward, and presents them on a valid/ready stream. It is the read-side counterpart of the convolution sequencer: the convolution engine writes a bank, this block reads it out.

## Interface
- DATA_W, 16, SRAM word and stream data width
- ADDR_W, 10, SRAM address width
- DEPTH, 800, words per pass (2 ≤ DEPTH ≤ 2^ADDR_W)

- clk  in  1  single clock, rising edge
- srstn  in  1  asynchronous active-low reset
- mode  in  2  convolution controller state (0 IDLE, 1 CONV1, 2 CONV2, 3 DONE)
- mem_sel  in  1  bank last written by convolution (0 = c bank, 1 = d bank)
- c_rd_en  out  1  c bank read strobe
- d_rd_en  out  1  d bank read strobe
- rd_addr  out  ADDR_W  read address, shared by both banks
- c_rdata  in  DATA_W  c bank data, valid the cycle after c_rd_en
- d_rdata  in  DATA_W  d bank data, valid the cycle after d_rd_en
- out_valid  out  1  stream word available
- out_ready  in  1  downstream accepts the word
- out_data  out  DATA_W  stream word
- out_last  out  1  marks word DEPTH-1
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when a pass completes
- overrun  out  1  one-cycle pulse when DONE arrives while busy

## Operation
- **States**
  - IDLE → READ when mode == 3. On that transition: bank <= mem_sel, issue address <= 0.
  - READ → DRAIN in the cycle the read of address DEPTH-1 is issued.
  - DRAIN → IDLE when the buffer is empty, no read is in flight and the final handshake has completed. done is pulsed on this transition.
- **Read issue**
  - Allowed in READ only when (count + inflight − pop) < 2, where:
    - count = buffer occupancy (0..2)
    - inflight = a read issued last cycle (0/1)
    - pop = out_valid & out_ready this cycle
  - On issue, exactly one of c_rd_en / d_rd_en is high, selected by the latched bank. rd_addr = issue address; the issue address then increments.
  - No read strobe is ever asserted outside READ.
- **Capture**
  - The cycle after an issue, the selected rdata is written into a 2-entry FIFO, together with a last flag set when the address was DEPTH-1.
  - The 2-entry capacity plus the issue rule guarantees no overflow and no data loss under any out_ready pattern.
- **Output**
  - out_valid = (count != 0). out_data and out_last come from the FIFO head.
  - The head is held stable while out_valid & ~out_ready.
- **Ignored inputs**
  - mode == 3 while busy is ignored for sequencing and raises overrun for one cycle.
  - mem_sel changes after the latch have no effect on the current pass.
  - mode values 0–2 never start a pass.
- **Reset**
  - Asynchronous assertion at any time, including mid-pass, forces IDLE, empties the FIFO and clears all counters and the in-flight flag.
  - No partial pass resumes after release.
- **Arithmetic**
  - The issue address counter is ADDR_W bits and never exceeds DEPTH-1. Returning to 0 happens only by the latch at the start of the next pass.

## Timing
- **Reset values**: all outputs 0 (c_rd_en, d_rd_en, rd_addr, out_valid, out_data, out_last, busy, done, overrun); state IDLE; latched bank 0.
- **Start latency**: mode == 3 sampled at edge E. busy and the first read strobe (address 0) are high in the cycle after E. The first out_valid is high two cycles after the first strobe.
- **Throughput**: with out_ready held high, one read strobe per cycle and one stream word per cycle. A full pass takes DEPTH + 2 cycles from the first strobe to the last handshake.
- **done**: asserted in the cycle after the out_last handshake; busy falls in that same cycle.
- **Back-to-back passes**: a mode == 3 in the same cycle as done is treated as busy, so it pulses overrun and does not start a pass. A mode == 3 one cycle later starts a new pass.
- **Backpressure release**: when out_ready rises again, reads resume in the same cycle, because pop is counted in the issue condition.

## Test plan
- **Basic c-bank pass**: reset, mem_sel=0, one cycle of mode=3, out_ready=1, c bank preloaded data[i]=i. Required: c_rd_en on addresses 0..799 in consecutive cycles; d_rd_en never high; 800 words 0..799 in order; out_last only on 799; done one cycle after it.
- **d-bank select and latch**: mem_sel=1 at DONE, toggled to 0 the next cycle. Required: only d_rd_en pulses for the whole pass; stream carries the d bank contents.
- **Random backpressure**: out_ready random at 30% duty, DEPTH=8. Required: 8 words in order with no drop or duplicate; out_data stable while stalled; count never exceeds 2; no strobe is issued when count + inflight − pop ≥ 2.
- **Overrun**: mode=3 pulsed again at read address 100. Required: overrun high for exactly one cycle; the pass continues to address 799; no restart.
- **Reset mid-pass**: srstn low asynchronously at word 300. Required: all outputs 0 immediately. A new DONE after release streams from address 0 with the full 800 words.
- **Ready low through READ**: out_ready=0 from start until 20 cycles later. Required: exactly 2 reads issued (addresses 0,1), then no strobes. After ready rises, 1 word per cycle, DEPTH+2-cycle tail as specified.

Source files
------------

// File: rtl/conv_bank_reader.sv
// Streams one convolution output bank (DEPTH words, address 0 upward) onto a valid/ready port after each DONE.
// First strobe 1 cycle after DONE, first word 2 cycles later; reads pause whenever the 2-entry buffer could overflow.
module conv_bank_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 800
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic [1:0]        mode,
  input  logic              mem_sel,
  output logic              c_rd_en,
  output logic              d_rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic [DATA_W-1:0] d_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic                bank;
  logic [ADDR_W-1:0]   addr;
  logic                inflight, inflight_last;
  logic [DATA_W-1:0]   fifo_data [2];
  logic                fifo_last [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;
  logic                done_q, overrun_q;
  logic                issue, pop, start, at_last, end_pass;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign at_last   = (addr == LAST_ADDR);
  // A pop in the same cycle frees a slot, so reads resume as soon as ready returns.
  assign issue     = (state == READ) &&
                     (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  // The cycle carrying done still counts as busy for a new DONE.
  assign start     = (state == IDLE) && (mode == 2'd3) && !done_q;

  always_comb begin
    state_nxt = state;
    end_pass  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = READ;
      READ:  if (issue && at_last) state_nxt = DRAIN;
      DRAIN: begin
        if (pop && out_last && !inflight && (count == 2'd1)) begin
          state_nxt = IDLE;
          end_pass  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state         <= IDLE;
      bank          <= 1'b0;
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last[0]  <= 1'b0;
      fifo_last[1]  <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        bank <= mem_sel;
        addr <= '0;
      end else if (issue && !at_last) begin
        addr <= addr + ADDR_W'(1);
      end
      inflight      <= issue;
      inflight_last <= issue && at_last;
      // Bank data arrives one cycle after its strobe; capture it into the buffer tail.
      if (inflight) begin
        fifo_data[wr_ptr] <= bank ? d_rdata : c_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count     <= count + {1'b0, inflight} - {1'b0, pop};
      done_q    <= end_pass;
      overrun_q <= (mode == 2'd3) && ((state != IDLE) || done_q);
    end
  end

  assign c_rd_en  = issue & ~bank;
  assign d_rd_en  = issue & bank;
  assign rd_addr  = addr;
  assign out_data = fifo_data[rd_ptr];
  assign out_last = out_valid & fifo_last[rd_ptr];
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_conv_bank_reader.sv
// Bench for conv_bank_reader: bank SRAM models, a stream scoreboard and a read/occupancy rule monitor.
module tb_conv_bank_reader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 800;

  logic              clk = 1'b0;
  logic              srstn;
  logic [1:0]        mode;
  logic              mem_sel;
  logic              c_rd_en, d_rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] c_rdata = '0;
  logic [DATA_W-1:0] d_rdata = '0;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last, busy, done, overrun;

  always #5 clk = ~clk;

  conv_bank_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .srstn(srstn), .mode(mode), .mem_sel(mem_sel),
    .c_rd_en(c_rd_en), .d_rd_en(d_rd_en), .rd_addr(rd_addr),
    .c_rdata(c_rdata), .d_rdata(d_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .overrun(overrun)
  );

  // Synchronous-read bank SRAMs
  logic [DATA_W-1:0] c_mem [DEPTH];
  logic [DATA_W-1:0] d_mem [DEPTH];
  always @(posedge clk) begin
    if (c_rd_en) c_rdata <= c_mem[rd_addr];
    if (d_rd_en) d_rdata <= d_mem[rd_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Monitor: per-pass statistics, reset by mon_clr
  bit                mon_clr;
  int                cyc = 0;
  int                iss, iss_lag, pops, n_strobe, c_cnt, d_cnt;
  int                addr_err, rule_err, valid_err, stall_err, both_err;
  int                last_cnt, last_idx, last_hs, first_hs, first_strobe, first_valid;
  int                done_cyc, done_cnt, ovr_cnt;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic [DATA_W-1:0] got [$];

  always @(negedge clk) begin
    int occ, infl;
    bit strobe, pop;
    cyc++;
    if (mon_clr) begin
      iss = 0; iss_lag = 0; pops = 0; n_strobe = 0; c_cnt = 0; d_cnt = 0;
      addr_err = 0; rule_err = 0; valid_err = 0; stall_err = 0; both_err = 0;
      last_cnt = 0; last_idx = -1; last_hs = -1; first_hs = -1;
      first_strobe = -1; first_valid = -1; done_cyc = -1; done_cnt = 0; ovr_cnt = 0;
      prev_stall = 1'b0; prev_data = '0;
      got.delete();
    end else begin
      strobe = c_rd_en | d_rd_en;
      pop    = out_valid & out_ready;
      // Buffer holds reads issued at least two cycles ago that have not yet been popped.
      occ  = iss_lag - pops;
      infl = iss - iss_lag;
      if (out_valid !== (occ != 0) || occ > 2) valid_err++;
      if (c_rd_en && d_rd_en) both_err++;
      if (strobe) begin
        if (occ + infl - int'(pop) >= 2) rule_err++;
        if (int'(rd_addr) != n_strobe) addr_err++;
        if (first_strobe < 0) first_strobe = cyc;
        n_strobe++;
        if (c_rd_en) c_cnt++;
        if (d_rd_en) d_cnt++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (pop) begin
        got.push_back(out_data);
        if (first_hs < 0) first_hs = cyc;
        if (out_last) begin
          last_cnt++;
          last_idx = got.size() - 1;
          last_hs  = cyc;
        end
      end
      if (overrun) ovr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      iss_lag = iss;
      iss     = iss + int'(strobe);
      pops    = pops + int'(pop);
    end
  end

  logic [DATA_W-1:0] exp_q [$];

  // Caller is #1 after a rising edge; DONE is presented for exactly one cycle.
  task automatic start_pass(input bit sel, input bit ramp);
    for (int i = 0; i < DEPTH; i++) begin
      c_mem[i] = ramp ? DATA_W'(i) : DATA_W'($urandom);
      d_mem[i] = DATA_W'($urandom);
    end
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(sel ? d_mem[i] : c_mem[i]);
    mon_clr = 1'b1;
    mem_sel = sel;
    mode    = 2'd3;
    @(posedge clk); #1;
    mode    = 2'd0;
    mon_clr = 1'b0;
    mem_sel = ~sel;
    chk("start_busy", busy, 1);
    chk("start_strobe", sel ? d_rd_en : c_rd_en, 1);
    chk("start_addr", rd_addr, 0);
  endtask

  task automatic wait_done(input bit rnd, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    out_ready = 1'b1;
  endtask

  task automatic check_pass(input bit sel, input int timing);
    int derr = 0;
    chk("word_count", got.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i >= got.size() || got[i] !== exp_q[i]) derr++;
    chk("data_order", derr, 0);
    chk("last_count", last_cnt, 1);
    chk("last_index", last_idx, DEPTH - 1);
    chk("done_after_last", done_cyc - last_hs, 1);
    chk("done_pulses", done_cnt, 1);
    chk("strobes", n_strobe, DEPTH);
    chk("wrong_bank_strobes", sel ? c_cnt : d_cnt, 0);
    chk("addr_seq", addr_err, 0);
    chk("issue_rule", rule_err, 0);
    chk("occupancy", valid_err, 0);
    chk("stall_stable", stall_err, 0);
    chk("both_strobes", both_err, 0);
    chk("idle_after", busy, 0);
    if (timing == 1) begin
      chk("first_valid_lat", first_valid - first_strobe, 2);
      chk("pass_length", last_hs - first_strobe, DEPTH + 1);
    end
    if (timing == 2) chk("resume_rate", last_hs - first_hs, DEPTH - 1);
  endtask

  initial begin
    bit hit;
    mon_clr   = 1'b1;
    srstn     = 1'b0;
    mode      = 2'd0;
    mem_sel   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_c_rd_en", c_rd_en, 0);
    chk("rst_d_rd_en", d_rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out", {out_valid, out_last, busy, done, overrun}, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1 srstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic c-bank pass with ramp data, ready always high
    start_pass(1'b0, 1'b1);
    wait_done(1'b0, 2000);
    @(posedge clk); #1;
    check_pass(1'b0, 1);

    // d bank, mem_sel toggles after the latch; DONE again in the done cycle
    start_pass(1'b1, 1'b0);
    wait_done(1'b0, 2000);
    mode = 2'd3;
    @(posedge clk); #1;
    mode = 2'd0;
    chk("b2b_overrun", overrun, 1);
    chk("b2b_no_start", busy, 0);
    check_pass(1'b1, 1);

    // Random 30% ready, started one cycle after the rejected DONE
    start_pass(1'b0, 1'b0);
    wait_done(1'b1, 8000);
    @(posedge clk); #1;
    check_pass(1'b0, 0);

    // Second DONE mid-pass at read address 100
    start_pass(1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (c_rd_en && rd_addr == ADDR_W'(100)) hit = 1'b1;
    end
    chk("addr100_reached", hit, 1);
    mode = 2'd3;
    @(posedge clk); #1;
    mode = 2'd0;
    wait_done(1'b0, 2000);
    @(posedge clk); #1;
    check_pass(1'b0, 1);
    chk("overrun_cycles", ovr_cnt, 1);

    // Asynchronous reset after 300 words
    start_pass(1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (got.size() >= 300) hit = 1'b1;
    end
    chk("word300_reached", hit, 1);
    #2 srstn = 1'b0;
    mon_clr = 1'b1;
    #1;
    chk("mid_rst_strobes", {c_rd_en, d_rd_en}, 0);
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_out", {out_valid, out_last, busy, done, overrun}, 0);
    chk("mid_rst_data", out_data, 0);
    @(posedge clk); #1 srstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume", {busy, c_rd_en, d_rd_en, out_valid}, 0);
    start_pass(1'b0, 1'b0);
    wait_done(1'b0, 2000);
    @(posedge clk); #1;
    check_pass(1'b0, 1);

    // Ready low from the start for 20 cycles
    out_ready = 1'b0;
    start_pass(1'b1, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    chk("stalled_strobes", n_strobe, 2);
    chk("stalled_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done(1'b0, 2000);
    @(posedge clk); #1;
    check_pass(1'b1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
